// File: rtl/bcd_to_bin_seq.sv
`default_nettype none
// ============================================================================
// bcd_to_bin_seq : sequential BCD-to-binary converter (reverse double-dabble).
// Optional invalid-digit check enabled by defining BCD_TO_BIN_CHECK_EN. Rev 1.0
// ============================================================================
module bcd_to_bin_seq #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [4*DIGITS-1:0] bcd_in,
  output logic                busy,
  output logic                done,
  output logic [BIN_W-1:0]    bin_out,
  output logic                err
);

  localparam int SR_W  = 4*DIGITS + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_shift = 2'd1;
  localparam logic [1:0] c_st_done  = 2'd2;

  localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(BIN_W - 1);

  logic [1:0]       r_state;
  logic [1:0]       w_next_state;
  logic [SR_W-1:0]  r_sreg;
  logic [SR_W-1:0]  w_shifted;
  logic [SR_W-1:0]  w_corrected;
  logic [CNT_W-1:0] r_cnt;
  logic [BIN_W-1:0] w_bin_next;
  logic             w_err_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= c_st_idle;
    else      r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_st_idle:  if (start) w_next_state = c_st_shift;
      c_st_shift: if (r_cnt == c_last_cnt) w_next_state = c_st_done;
      c_st_done:  w_next_state = c_st_idle;
      default:    w_next_state = c_st_idle;
    endcase
  end

  always_comb begin
    busy = (r_state != c_st_idle);
  end

  // Shift right, then pull every BCD digit that reached >= 8 back down by 3.
  assign w_shifted                = r_sreg >> 1;
  assign w_corrected[BIN_W-1:0]   = w_shifted[BIN_W-1:0];

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign w_corrected[BIN_W+4*gi +: 4] = w_shifted[BIN_W+4*gi+3]
                                          ? (w_shifted[BIN_W+4*gi +: 4] - 4'd3)
                                          :  w_shifted[BIN_W+4*gi +: 4];
    end
  endgenerate

`ifdef BCD_TO_BIN_CHECK_EN
  logic [DIGITS-1:0] w_digit_bad;
  logic              r_bad;

  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_check
      assign w_digit_bad[gi] = (bcd_in[4*gi +: 4] > 4'd9);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                             r_bad <= 1'b0;
    else if (r_state == c_st_idle && start) r_bad <= |w_digit_bad;
  end

  assign w_err_next = r_bad;
  assign w_bin_next = r_bad ? '0 : r_sreg[BIN_W-1:0];
`else
  assign w_err_next = 1'b0;
  assign w_bin_next = r_sreg[BIN_W-1:0];
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sreg  <= '0;
      r_cnt   <= '0;
      done    <= 1'b0;
      bin_out <= '0;
      err     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        c_st_idle: begin
          if (start) begin
            r_sreg <= {bcd_in, {BIN_W{1'b0}}};
            r_cnt  <= '0;
          end
        end
        c_st_shift: begin
          r_sreg <= w_corrected;
          r_cnt  <= r_cnt + 1'b1;
        end
        c_st_done: begin
          bin_out <= w_bin_next;
          err     <= w_err_next;
          done    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
